// File: rtl/pad_filter_pkg.sv
// pad_filter_pkg: FSM encoding and counter-width helpers shared by the pad_filter slice
package pad_filter_pkg;
  typedef enum logic {IDLE, ACTIVE} state_t;
  localparam int DEF_OUT_ROWS = 40;
  localparam int DEF_OUT_COLS = 40;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/pixel_out_reg.sv
// pixel_out_reg: output pixel/flag register that holds its contents until downstream takes them
module pixel_out_reg #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic         sof,
  input  logic         eol,
  input  logic         eof,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] pixel_out,
  output logic         out_sof,
  output logic         out_eol,
  output logic         out_eof
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      out_valid <= 1'b0;
      pixel_out <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      pixel_out <= data;
      out_sof   <= sof;
      out_eol   <= eol;
      out_eof   <= eof;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
endmodule

// File: rtl/pad_filter.sv
// pad_filter: re-embeds a cropped window stream into a full frame, padding outside the window
module pad_filter
  import pad_filter_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = 12,
  parameter int IN_ROWS = 20,
  parameter int IN_COLS = 20,
  parameter int OUT_ROWS = DEF_OUT_ROWS,
  parameter int OUT_COLS = DEF_OUT_COLS,
  parameter int Y_1 = 10,
  parameter int X_1 = 10,
  parameter logic [PIXEL_BIT_WIDTH-1:0] PAD_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_sof,
  output logic                       out_eol,
  output logic                       out_eof
);
  localparam int XW = cnt_w(OUT_COLS);
  localparam int YW = cnt_w(OUT_ROWS);
  localparam logic [XW-1:0] X_LAST = XW'(OUT_COLS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(OUT_ROWS - 1);
  localparam logic [XW-1:0] X_LO = XW'(X_1);
  localparam logic [XW-1:0] X_HI = XW'(X_1 + IN_COLS);
  localparam logic [YW-1:0] Y_LO = YW'(Y_1);
  localparam logic [YW-1:0] Y_HI = YW'(Y_1 + IN_ROWS);
  if (Y_1 + IN_ROWS > OUT_ROWS || X_1 + IN_COLS > OUT_COLS) begin : g_bad_geometry
    $error("pad_filter: window does not fit inside the output frame");
  end
  state_t state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic in_win, free, load, last_x, last_y;
  always_comb begin
    in_win   = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);
    free     = !out_valid || out_ready;
    last_x   = x == X_LAST;
    last_y   = y == Y_LAST;
    in_ready = (state == ACTIVE) && free && in_win;
    load     = (state == ACTIVE) && free && (!in_win || in_valid);
  end
  // counters track the position of the next pixel to load, not the one on the output
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
    end else begin
      state <= (state == IDLE) ? (in_valid ? ACTIVE : IDLE) : (load && last_x && last_y ? IDLE : ACTIVE);
      if (load) begin
        x <= last_x ? '0 : x + XW'(1);
        y <= last_x ? (last_y ? '0 : y + YW'(1)) : y;
      end
    end
  pixel_out_reg #(.W(PIXEL_BIT_WIDTH)) u_out (
    .clk(clk),
    .reset(reset),
    .load(load),
    .data(in_win ? pixel_in : PAD_VALUE),
    .sof(x == '0 && y == '0),
    .eol(last_x),
    .eof(last_x && last_y),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .pixel_out(pixel_out),
    .out_sof(out_sof),
    .out_eol(out_eol),
    .out_eof(out_eof)
  );
endmodule

// File: tb/tb_pad_filter.sv
// tb_pad_filter: random-flow bench comparing two pad_filter instances (zero and all-ones pad) to a frame model
module tb_pad_filter;
  localparam int W = 12, IR = 2, IC = 2, ORW = 6, OCL = 6, Y1 = 2, X1 = 2;
  localparam int NPIX = ORW * OCL;
  localparam int LIM = 20000;
  logic clk = 1'b0, reset = 1'b0;
  logic [W-1:0] pixel_in = '0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready_a, out_valid_a, sof_a, eol_a, eof_a;
  logic in_ready_b, out_valid_b, sof_b, eol_b, eof_b;
  logic [W-1:0] pix_a, pix_b;
  always #5 clk = ~clk;
  pad_filter #(.PIXEL_BIT_WIDTH(W), .IN_ROWS(IR), .IN_COLS(IC), .OUT_ROWS(ORW), .OUT_COLS(OCL),
               .Y_1(Y1), .X_1(X1), .PAD_VALUE(12'h000)) dut_a (
    .clk(clk), .reset(reset), .pixel_in(pixel_in), .in_valid(in_valid), .in_ready(in_ready_a),
    .pixel_out(pix_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_sof(sof_a), .out_eol(eol_a), .out_eof(eof_a));
  pad_filter #(.PIXEL_BIT_WIDTH(W), .IN_ROWS(IR), .IN_COLS(IC), .OUT_ROWS(ORW), .OUT_COLS(OCL),
               .Y_1(Y1), .X_1(X1), .PAD_VALUE(12'hFFF)) dut_b (
    .clk(clk), .reset(reset), .pixel_in(pixel_in), .in_valid(in_valid), .in_ready(in_ready_b),
    .pixel_out(pix_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sof(sof_b), .out_eol(eol_b), .out_eof(eof_b));
  int total = 0, bad = 0;
  logic [W-1:0] src[$];
  int src_idx = 0, fbase = 0, pos = 0, frames = 0, cyc = 0;
  int p_gap = 0, p_stall = 0, sof_cyc = 0, f0 = 0;
  bit hold_prev = 0, after_eof = 0, check_bubble = 0;
  logic [W+2:0] held_a, held_b;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // expected frame pixel at raster position p: window pixels come from the offered stream
  function automatic logic [W-1:0] expect_pix(input int p, input logic [W-1:0] pad);
    int r, c;
    r = p / OCL;
    c = p % OCL;
    if (r >= Y1 && r < Y1 + IR && c >= X1 && c < X1 + IC) return src[fbase + (r - Y1) * IC + (c - X1)];
    return pad;
  endfunction
  task automatic tick();
    bit acc;
    logic [2:0] ef;
    @(negedge clk);
    cyc++;
    if (hold_prev) begin
      chk("hold_valid", 32'(out_valid_a), 1);
      chk("hold_a", 32'({pix_a, sof_a, eol_a, eof_a}), 32'(held_a));
      chk("hold_b", 32'({pix_b, sof_b, eol_b, eof_b}), 32'(held_b));
    end
    hold_prev = out_valid_a && !out_ready;
    held_a = {pix_a, sof_a, eol_a, eof_a};
    held_b = {pix_b, sof_b, eol_b, eof_b};
    chk("ready_when_busy", 32'(in_ready_a && out_valid_a && !out_ready), 0);
    chk("ready_ab", 32'(in_ready_b), 32'(in_ready_a));
    chk("valid_ab", 32'(out_valid_b), 32'(out_valid_a));
    if (after_eof) begin
      if (check_bubble) chk("idle_bubble", 32'(out_valid_a), 0);
      after_eof = 0;
    end
    if (out_valid_a && out_ready) begin
      ef = {pos == 0, pos % OCL == OCL - 1, pos == NPIX - 1};
      chk("pix_a", 32'(pix_a), 32'(expect_pix(pos, 12'h000)));
      chk("pix_b", 32'(pix_b), 32'(expect_pix(pos, 12'hFFF)));
      chk("flags_a", 32'({sof_a, eol_a, eof_a}), 32'(ef));
      chk("flags_b", 32'({sof_b, eol_b, eof_b}), 32'(ef));
      if (pos == 0) sof_cyc = cyc;
      if (pos == NPIX - 1) begin
        if (check_bubble) chk("back_to_back", 32'(cyc - sof_cyc), NPIX - 1);
        frames++;
        fbase += IR * IC;
        pos = 0;
        after_eof = 1;
      end else pos++;
    end
    acc = in_valid && in_ready_a;
    @(posedge clk);
    #1;
    if (acc) src_idx++;
    out_ready = $urandom_range(99) >= p_stall;
    in_valid = (src_idx < src.size()) && ((in_valid && !acc) || $urandom_range(99) >= p_gap);
    pixel_in = (src_idx < src.size()) ? src[src_idx] : '0;
  endtask
  initial begin
    logic [W-1:0] v;
    for (int i = 1; i <= 8; i++) src.push_back(W'(i));
    for (int i = 0; i < 40; i++) begin
      v = W'($urandom);
      src.push_back(v);
    end
    in_valid = 1'b1;
    pixel_in = src[0];
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid_a), 0);
    chk("rst_pix", 32'(pix_a), 0);
    chk("rst_flags", 32'({sof_a, eol_a, eof_a}), 0);
    chk("rst_ready", 32'(in_ready_a), 0);
    chk("rst_pix_b", 32'(pix_b), 0);
    reset = 1'b1;
    check_bubble = 1;
    while (frames < 2 && cyc < LIM) tick();
    chk("continuous_done", 32'(frames), 2);
    check_bubble = 0;
    p_gap = 40;
    p_stall = 30;
    while (frames < 5 && cyc < LIM) tick();
    chk("random_done", 32'(frames), 5);
    while (pos != 3 * OCL && cyc < LIM) tick();
    chk("reached_row3", 32'(pos), 3 * OCL);
    #2 reset = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid_a), 0);
    chk("midrst_valid_b", 32'(out_valid_b), 0);
    chk("midrst_pix", 32'(pix_a), 0);
    chk("midrst_ready", 32'(in_ready_a), 0);
    hold_prev = 0;
    after_eof = 0;
    pos = 0;
    fbase = src_idx;
    f0 = frames;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    p_gap = 20;
    p_stall = 20;
    while (frames < f0 + 2 && cyc < LIM) tick();
    chk("after_reset_done", 32'(frames), 32'(f0 + 2));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
